lsu_arbiter: RTL and testbench

Two-port arbiter that shares the single load-store unit between the CPU memory stage (port 0) and the debug/program loader (port 1). Each cycle it selects at most one request and drives the LSU's address, write-enable, length and store-data inputs. It registers load results back to the winning port one cycle later. Port 0 has fixed priority; a starvation counter guarantees port 1 a grant within a bounded number of cycles.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_arbiter_if.sv | 41 ++++
 rtl/lsu_arb_rsp.sv | 26 ++
 rtl/lsu_arbiter.sv | 77 +++++++
 tb/tb_lsu_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU request types and length encodings, used by the arbiter, the LSU
// and any future requester.
package lsu_pkg;

  localparam int NUM_PORTS = 2;

  localparam logic [1:0] S_BYTE = 2'b00;
  localparam logic [1:0] S_HALF = 2'b01;
  localparam logic [1:0] S_WORD = 2'b10;

  localparam logic [2:0] L_B  = 3'b000;
  localparam logic [2:0] L_H  = 3'b001;
  localparam logic [2:0] L_W  = 3'b010;
  localparam logic [2:0] L_BU = 3'b100;
  localparam logic [2:0] L_HU = 3'b101;

  typedef struct packed {
    logic        wren;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [1:0]  s_length;
    logic [2:0]  l_length;
    logic        l_unsigned;
  } lsu_req_t;

endpackage

// File: rtl/lsu_arbiter_if.sv
// Requester/LSU bundle around the arbiter: master is the requester and LSU
// side, slave is the arbiter.
interface lsu_arbiter_if;
  logic        i_p0_req,      i_p1_req;
  logic        i_p0_wren,     i_p1_wren;
  logic [31:0] i_p0_addr,     i_p1_addr;
  logic [31:0] i_p0_st_data,  i_p1_st_data;
  logic [1:0]  i_p0_s_length, i_p1_s_length;
  logic [2:0]  i_p0_l_length, i_p1_l_length;
  logic        i_p0_l_unsigned, i_p1_l_unsigned;
  logic        o_p0_gnt,      o_p1_gnt;
  logic        o_p0_rsp_valid, o_p1_rsp_valid;
  logic [31:0] o_p0_rdata,    o_p1_rdata;
  logic [31:0] o_lsu_addr;
  logic        o_lsu_wren;
  logic [31:0] o_lsu_st_data;
  logic [1:0]  o_lsu_s_length;
  logic [2:0]  o_lsu_l_length;
  logic        o_lsu_l_unsigned;
  logic [31:0] i_lsu_ld_data;

  modport master (
    output i_p0_req, i_p1_req, i_p0_wren, i_p1_wren, i_p0_addr, i_p1_addr,
           i_p0_st_data, i_p1_st_data, i_p0_s_length, i_p1_s_length,
           i_p0_l_length, i_p1_l_length, i_p0_l_unsigned, i_p1_l_unsigned,
           i_lsu_ld_data,
    input  o_p0_gnt, o_p1_gnt, o_p0_rsp_valid, o_p1_rsp_valid,
           o_p0_rdata, o_p1_rdata, o_lsu_addr, o_lsu_wren, o_lsu_st_data,
           o_lsu_s_length, o_lsu_l_length, o_lsu_l_unsigned
  );

  modport slave (
    input  i_p0_req, i_p1_req, i_p0_wren, i_p1_wren, i_p0_addr, i_p1_addr,
           i_p0_st_data, i_p1_st_data, i_p0_s_length, i_p1_s_length,
           i_p0_l_length, i_p1_l_length, i_p0_l_unsigned, i_p1_l_unsigned,
           i_lsu_ld_data,
    output o_p0_gnt, o_p1_gnt, o_p0_rsp_valid, o_p1_rsp_valid,
           o_p0_rdata, o_p1_rdata, o_lsu_addr, o_lsu_wren, o_lsu_st_data,
           o_lsu_s_length, o_lsu_l_length, o_lsu_l_unsigned
  );
endinterface

// File: rtl/lsu_arb_rsp.sv
// Per-port load response register: captures LSU load data at the end of a
// granted load cycle and flags it valid for one cycle.
module lsu_arb_rsp (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        gnt,
  input  logic        wren,
  input  logic [31:0] ld_data,
  output logic        rsp_valid,
  output logic [31:0] rdata
);

  logic ld_hit;
  assign ld_hit = gnt & ~wren;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid <= 1'b0;
      rdata     <= '0;
    end else begin
      rsp_valid <= ld_hit;
      if (ld_hit) rdata <= ld_data;
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-port LSU arbiter: port 0 fixed priority, port 1 protected from
// starvation by a saturating wait counter.
module lsu_arbiter
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  lsu_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  lsu_req_t [NUM_PORTS-1:0]       req;
  logic     [NUM_PORTS-1:0]       req_v;
  logic     [NUM_PORTS-1:0]       gnt;
  logic     [NUM_PORTS-1:0]       wren;
  logic     [NUM_PORTS-1:0]       rsp_vld;
  logic     [NUM_PORTS-1:0][31:0] rsp_data;
  lsu_req_t                       sel;
  logic     [3:0]                 wait_cnt;
  logic                           starve;

  assign req_v  = {bus.i_p1_req, bus.i_p0_req};
  assign req[0] = '{wren: bus.i_p0_wren, addr: bus.i_p0_addr, st_data: bus.i_p0_st_data,
                    s_length: bus.i_p0_s_length, l_length: bus.i_p0_l_length,
                    l_unsigned: bus.i_p0_l_unsigned};
  assign req[1] = '{wren: bus.i_p1_wren, addr: bus.i_p1_addr, st_data: bus.i_p1_st_data,
                    s_length: bus.i_p1_s_length, l_length: bus.i_p1_l_length,
                    l_unsigned: bus.i_p1_l_unsigned};

  // Port 1 overrides port 0 only once it has been denied MAX_WAIT cycles in a row.
  assign starve = (wait_cnt == MAX_W);
  assign gnt[0] = req_v[0] & ~(req_v[1] & starve);
  assign gnt[1] = req_v[1] & ~gnt[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 wait_cnt <= '0;
    else if (!req_v[1] || gnt[1]) wait_cnt <= '0;
    else if (!starve)             wait_cnt <= wait_cnt + 4'd1;
  end

  always_comb begin
    sel = '0;
    if (gnt[0])      sel = req[0];
    else if (gnt[1]) sel = req[1];
  end

  assign bus.o_lsu_addr       = sel.addr;
  assign bus.o_lsu_wren       = sel.wren;
  assign bus.o_lsu_st_data    = sel.st_data;
  assign bus.o_lsu_s_length   = sel.s_length;
  assign bus.o_lsu_l_length   = sel.l_length;
  assign bus.o_lsu_l_unsigned = sel.l_unsigned;

  assign bus.o_p0_gnt = gnt[0];
  assign bus.o_p1_gnt = gnt[1];

  assign wren = {req[1].wren, req[0].wren};

  lsu_arb_rsp u_rsp [NUM_PORTS-1:0] (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .gnt       (gnt),
    .wren      (wren),
    .ld_data   (bus.i_lsu_ld_data),
    .rsp_valid (rsp_vld),
    .rdata     (rsp_data)
  );

  assign bus.o_p0_rsp_valid = rsp_vld[0];
  assign bus.o_p1_rsp_valid = rsp_vld[1];
  assign bus.o_p0_rdata     = rsp_data[0];
  assign bus.o_p1_rdata     = rsp_data[1];

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: a small LSU memory stub plus a transaction-level
// reference model of grants, LSU fields and load responses.
module tb_lsu_arbiter;
  import lsu_pkg::*;

  localparam int MAX_WAIT = 4;

  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  lsu_arbiter_if bus ();

  lsu_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk   (i_clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  lsu_req_t r0, r1;
  logic     p0_req, p1_req;

  assign bus.i_p0_req        = p0_req;
  assign bus.i_p0_wren       = r0.wren;
  assign bus.i_p0_addr       = r0.addr;
  assign bus.i_p0_st_data    = r0.st_data;
  assign bus.i_p0_s_length   = r0.s_length;
  assign bus.i_p0_l_length   = r0.l_length;
  assign bus.i_p0_l_unsigned = r0.l_unsigned;
  assign bus.i_p1_req        = p1_req;
  assign bus.i_p1_wren       = r1.wren;
  assign bus.i_p1_addr       = r1.addr;
  assign bus.i_p1_st_data    = r1.st_data;
  assign bus.i_p1_s_length   = r1.s_length;
  assign bus.i_p1_l_length   = r1.l_length;
  assign bus.i_p1_l_unsigned = r1.l_unsigned;

  // LSU stub: word memory, width/sign handling lives here as it does in the real LSU
  logic [31:0] mem [0:255];

  function automatic logic [31:0] lsu_load(logic [31:0] w, logic [31:0] a, logic [2:0] ll);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a[1:0]));
    h = a[1] ? w[31:16] : w[15:0];
    case (ll)
      L_B:     return {{24{b[7]}}, b};
      L_BU:    return {24'd0, b};
      L_H:     return {{16{h[15]}}, h};
      L_HU:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign bus.i_lsu_ld_data = lsu_load(mem[bus.o_lsu_addr[9:2]], bus.o_lsu_addr, bus.o_lsu_l_length);

  always @(posedge i_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.o_lsu_wren) begin
      case (bus.o_lsu_s_length)
        S_BYTE:  mem[bus.o_lsu_addr[9:2]][8*bus.o_lsu_addr[1:0] +: 8] <= bus.o_lsu_st_data[7:0];
        S_HALF:  mem[bus.o_lsu_addr[9:2]][16*bus.o_lsu_addr[1] +: 16] <= bus.o_lsu_st_data[15:0];
        default: mem[bus.o_lsu_addr[9:2]] <= bus.o_lsu_st_data;
      endcase
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model state: consecutive denied port-1 cycles and expected responses
  int          denied;
  logic [1:0]  exp_vld;
  logic [31:0] exp_rdata [2];

  task automatic model_reset();
    denied       = 0;
    exp_vld      = '0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // One clock: called just after a negedge with inputs driven, returns at next negedge
  task automatic step(output logic g0, output logic g1);
    logic     ew0, ew1;
    lsu_req_t w;
    logic [31:0] eld;
    int       nd;
    #1;
    ew0 = p0_req && !(p1_req && denied == MAX_WAIT);
    ew1 = p1_req && !ew0;
    chk("p0_gnt", 32'(bus.o_p0_gnt), 32'(ew0));
    chk("p1_gnt", 32'(bus.o_p1_gnt), 32'(ew1));
    w = ew0 ? r0 : (ew1 ? r1 : '0);
    chk("lsu_addr", bus.o_lsu_addr, w.addr);
    chk("lsu_wren", 32'(bus.o_lsu_wren), 32'(w.wren));
    chk("lsu_st_data", bus.o_lsu_st_data, w.st_data);
    chk("lsu_len", {bus.o_lsu_s_length, bus.o_lsu_l_length, bus.o_lsu_l_unsigned},
        {w.s_length, w.l_length, w.l_unsigned});
    eld = lsu_load(mem[w.addr[9:2]], w.addr, w.l_length);
    nd  = (p1_req && !ew1) ? ((denied < MAX_WAIT) ? denied + 1 : denied) : 0;
    @(posedge i_clk);
    denied     = nd;
    exp_vld[0] = ew0 && !w.wren;
    exp_vld[1] = ew1 && !w.wren;
    if (exp_vld[0]) exp_rdata[0] = eld;
    if (exp_vld[1]) exp_rdata[1] = eld;
    @(negedge i_clk);
    chk("p0_rsp_valid", 32'(bus.o_p0_rsp_valid), 32'(exp_vld[0]));
    chk("p1_rsp_valid", 32'(bus.o_p1_rsp_valid), 32'(exp_vld[1]));
    chk("p0_rdata", bus.o_p0_rdata, exp_rdata[0]);
    chk("p1_rdata", bus.o_p1_rdata, exp_rdata[1]);
    g0 = ew0;
    g1 = ew1;
  endtask

  function automatic lsu_req_t mk(logic wr, logic [31:0] a, logic [31:0] d,
                                  logic [1:0] sl, logic [2:0] ll);
    lsu_req_t r;
    r.wren       = wr;
    r.addr       = a;
    r.st_data    = d;
    r.s_length   = sl;
    r.l_length   = ll;
    r.l_unsigned = ll[2];
    return r;
  endfunction

  function automatic lsu_req_t rnd_req();
    logic [2:0] lls [5];
    lls = '{L_B, L_H, L_W, L_BU, L_HU};
    return mk(1'($urandom_range(0, 1)), 32'h2000 + 32'($urandom_range(0, 31)) * 4,
              $urandom, 2'($urandom_range(0, 2)), lls[$urandom_range(0, 4)]);
  endfunction

  logic g0, g1;
  logic pend0, pend1;

  initial begin
    p0_req = 0; p1_req = 0; r0 = '0; r1 = '0;
    model_reset();

    // reset state
    repeat (2) @(negedge i_clk);
    chk("rst_rsp_valid", {30'd0, bus.o_p1_rsp_valid, bus.o_p0_rsp_valid}, 32'd0);
    chk("rst_rdata0", bus.o_p0_rdata, 32'd0);
    chk("rst_rdata1", bus.o_p1_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge i_clk);

    // store word from port 0, read back from port 1
    p0_req = 1; r0 = mk(1, 32'h2000, 32'hDEADBEEF, S_WORD, L_W);
    step(g0, g1);
    chk("st_gnt0", 32'(g0), 32'd1);
    p0_req = 0; p1_req = 1; r1 = mk(0, 32'h2000, 32'h0, S_WORD, L_W);
    step(g0, g1);
    chk("ld_p1_valid", 32'(bus.o_p1_rsp_valid), 32'd1);
    chk("ld_p1_beef", bus.o_p1_rdata, 32'hDEADBEEF);
    p1_req = 0;
    step(g0, g1);

    // byte loads from LEDR location
    p0_req = 1; r0 = mk(1, 32'h7000, 32'h85, S_BYTE, L_W);
    step(g0, g1);
    r0 = mk(0, 32'h7000, 32'h0, S_WORD, L_BU);
    step(g0, g1);
    chk("ld_bu", bus.o_p0_rdata, 32'h00000085);
    r0 = mk(0, 32'h7000, 32'h0, S_WORD, L_B);
    step(g0, g1);
    chk("ld_b", bus.o_p0_rdata, 32'hFFFFFF85);
    p0_req = 0;
    step(g0, g1);
    chk("ld_b_pulse", 32'(bus.o_p0_rsp_valid), 32'd0);
    chk("ld_b_hold", bus.o_p0_rdata, 32'hFFFFFF85);

    // continuous contention: p1 wins every fifth cycle
    p0_req = 1; p1_req = 1;
    r0 = mk(0, 32'h2000, 0, S_WORD, L_W);
    r1 = mk(0, 32'h7000, 0, S_WORD, L_W);
    for (int k = 0; k < 10; k++) begin
      step(g0, g1);
      chk("pattern_p1", 32'(g1), 32'(k % 5 == 4));
      chk("pattern_one", 32'(g0 ^ g1), 32'd1);
    end
    p0_req = 0; p1_req = 0;
    step(g0, g1);

    // port 1 alone, back-to-back loads at distinct words
    p0_req = 1;
    for (int k = 0; k < 3; k++) begin
      r0 = mk(1, 32'h2100 + 32'(k) * 4, 32'hA5A50000 + 32'(k), S_WORD, L_W);
      step(g0, g1);
    end
    p0_req = 0; p1_req = 1;
    for (int k = 0; k < 3; k++) begin
      r1 = mk(0, 32'h2100 + 32'(k) * 4, 0, S_WORD, L_W);
      step(g0, g1);
      chk("b2b_gnt1", 32'(g1), 32'd1);
      chk("b2b_data", bus.o_p1_rdata, 32'hA5A50000 + 32'(k));
    end
    p1_req = 0;
    step(g0, g1);

    // withdrawn port-1 request restarts its wait
    p0_req = 1; p1_req = 1;
    repeat (2) begin
      step(g0, g1);
      chk("wd_pre_p0", 32'(g0), 32'd1);
    end
    p1_req = 0;
    step(g0, g1);
    p1_req = 1;
    for (int k = 0; k < 5; k++) begin
      step(g0, g1);
      chk("wd_post_p1", 32'(g1), 32'(k == 4));
    end
    p0_req = 0; p1_req = 0;
    step(g0, g1);

    // reset in the middle of a load response
    p0_req = 1; r0 = mk(0, 32'h2000, 0, S_WORD, L_W);
    step(g0, g1);
    p0_req = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {30'd0, bus.o_p1_rsp_valid, bus.o_p0_rsp_valid}, 32'd0);
    chk("mid_rst_rdata0", bus.o_p0_rdata, 32'd0);
    chk("mid_rst_wren", 32'(bus.o_lsu_wren), 32'd0);
    model_reset();
    @(negedge i_clk);
    rst_n = 1'b1;
    @(negedge i_clk);

    // randomized traffic, requests held until granted
    pend0 = 0; pend1 = 0;
    for (int k = 0; k < 400; k++) begin
      if (!pend0 && $urandom_range(0, 9) < 6) begin pend0 = 1; r0 = rnd_req(); end
      if (!pend1 && $urandom_range(0, 9) < 6) begin pend1 = 1; r1 = rnd_req(); end
      p0_req = pend0; p1_req = pend1;
      step(g0, g1);
      if (g0) pend0 = 0;
      if (g1) pend1 = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
